design1_wrapper: RTL and testbench

Fan-control datapath of the sigma-delta block design. It turns a programmable fan-speed level into a first-order sigma-delta pulse-density stream on the board's active-low fan enable, `fan_en_b`. It sits behind the PS register interface, which supplies level, prescale and enable. The block is fail-safe: the fan runs at full speed whenever the block is in reset or disabled.

---
 rtl/design1_wrapper.sv | 127 ++++++++++++
 tb/tb_design1_wrapper.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/design1_wrapper.sv
// rtl/design1_wrapper.sv - first-order sigma-delta fan-speed modulator
//
// Converts a programmable fan-speed level into a pulse-density stream on
// the active-low fan enable. The fan is driven full-on while the block is
// in reset or disabled. Unlike the usual default, this block uses an
// asynchronous active-high reset, ps_areset. It also has a synchronous
// soft_reset with the same effect.
//
// Ports:
//   ps_clk       in   clock, rising edge
//   ps_areset    in   asynchronous active-high reset
//   soft_reset   in   synchronous active-high reset, overrides all inputs
//   enable       in   1 = modulate, 0 = fan forced full-on
//   level        in   pulse density, duty = level / 2^DATA_WIDTH
//   prescale     in   one modulator tick every prescale+1 cycles
//   fan_en_b     out  active-low fan drive, registered
//   pdm_bit      out  modulator carry from the last tick, registered
//   kick_active  out  high during kick-start (0 when compiled out)
//
// Optional feature macro: FAN_KICKSTART_EN (kick-start on enable rise)

module design1_wrapper #(
    parameter int DATA_WIDTH     = 16,
    parameter int PRESCALE_WIDTH = 16,
    parameter int KICK_CYCLES    = 1024
) (
    input  logic                      ps_clk,
    input  logic                      ps_areset,
    input  logic                      soft_reset,
    input  logic                      enable,
    input  logic [DATA_WIDTH-1:0]     level,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      fan_en_b,
    output logic                      pdm_bit,
    output logic                      kick_active
);

    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0]     r_acc;
    logic                      r_pdm_bit;
    logic                      r_fan_en_b;

    logic [DATA_WIDTH:0]       w_sum;
    logic                      w_hold_kick;
    logic                      w_tick;

    // Carry out of the accumulator is the pulse-density bit.
    assign w_sum = {1'b0, r_acc} + {1'b0, level};

`ifdef FAN_KICKSTART_EN
    localparam int KICK_W = $clog2(KICK_CYCLES + 1);

    logic [KICK_W-1:0] r_kick_cnt;
    logic              r_enable_d;
    logic              w_kick_start;

    // A kick only makes sense when the requested level would spin the fan.
    assign w_kick_start = enable && !r_enable_d && (level != '0);
    // The trigger cycle itself is already part of the kick, so no tick
    // can disturb the accumulator before the counter is loaded.
    assign w_hold_kick  = w_kick_start || (r_kick_cnt != '0);
    // Gated by enable so a falling enable drops the flag without waiting
    // for the counter register to clear.
    assign kick_active  = enable && (r_kick_cnt != '0);

    always_ff @(posedge ps_clk or posedge ps_areset) begin
        if (ps_areset) begin
            r_kick_cnt <= '0;
            r_enable_d <= 1'b0;
        end else if (soft_reset) begin
            r_kick_cnt <= '0;
            r_enable_d <= 1'b0;
        end else begin
            r_enable_d <= enable;
            if (!enable) begin
                r_kick_cnt <= '0;
            end else if (w_kick_start) begin
                r_kick_cnt <= KICK_W'(KICK_CYCLES);
            end else if (r_kick_cnt != '0) begin
                r_kick_cnt <= r_kick_cnt - KICK_W'(1);
            end
        end
    end
`else
    assign w_hold_kick = 1'b0;
    // KICK_CYCLES has no role without the kick-start feature.
    assign kick_active = 1'b0 & (KICK_CYCLES != 0);
`endif

    // Using >= lets a lowered prescale take effect without waiting for a wrap.
    assign w_tick = enable && !w_hold_kick && (r_cnt >= prescale);

    always_ff @(posedge ps_clk or posedge ps_areset) begin
        if (ps_areset) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_pdm_bit  <= 1'b0;
            r_fan_en_b <= 1'b0;
        end else if (soft_reset) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_pdm_bit  <= 1'b0;
            r_fan_en_b <= 1'b0;
        end else if (!enable) begin
            // Disabled: fan full-on, modulator restarts from zero later.
            r_cnt      <= '0;
            r_acc      <= '0;
            r_pdm_bit  <= 1'b0;
            r_fan_en_b <= 1'b0;
        end else if (w_hold_kick) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_fan_en_b <= 1'b0;
        end else if (w_tick) begin
            r_cnt      <= '0;
            r_acc      <= w_sum[DATA_WIDTH-1:0];
            r_pdm_bit  <= w_sum[DATA_WIDTH];
            r_fan_en_b <= ~w_sum[DATA_WIDTH];
        end else begin
            r_cnt      <= r_cnt + PRESCALE_WIDTH'(1);
        end
    end

    assign fan_en_b = r_fan_en_b;
    assign pdm_bit  = r_pdm_bit;

endmodule

// File: tb/tb_design1_wrapper.sv
// tb/tb_design1_wrapper.sv - scoreboard bench for design1_wrapper

module tb_design1_wrapper;

    logic        ps_clk = 1'b0;
    logic        ps_areset = 1'b0;
    logic        soft_reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] level = 16'h0000;
    logic [15:0] prescale = 16'h0000;
    logic        fan_en_b;
    logic        pdm_bit;
    logic        kick_active;

    int total = 0;
    int bad = 0;

    // Expected {fan_en_b, pdm_bit, kick_active} after the next rising edge.
    logic [2:0] q_exp[$];
    string      q_name[$];

    design1_wrapper #(
        .DATA_WIDTH(16),
        .PRESCALE_WIDTH(16),
        .KICK_CYCLES(1024)
    ) dut (
        .ps_clk(ps_clk),
        .ps_areset(ps_areset),
        .soft_reset(soft_reset),
        .enable(enable),
        .level(level),
        .prescale(prescale),
        .fan_en_b(fan_en_b),
        .pdm_bit(pdm_bit),
        .kick_active(kick_active)
    );

    always #5 ps_clk = ~ps_clk;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {fan,pdm,kick}=%b expected %b", name, act, exp);
        end
    endtask

    // Monitor: one expectation per rising edge, sampled 1 time unit later.
    always @(posedge ps_clk) begin
        logic [2:0] e;
        string      n;
        #1;
        if (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            n = q_name.pop_front();
            check(n, {fan_en_b, pdm_bit, kick_active}, e);
        end
    end

    // Called just after a falling edge with inputs already set.
    task automatic cyc(input string name, input logic fan, input logic pdm, input logic kick = 1'b0);
        q_exp.push_back({fan, pdm, kick});
        q_name.push_back(name);
        @(negedge ps_clk);
    endtask

    // Expected outputs while a kick-start runs after an enable rise with a nonzero level.
    task automatic kick_wait(input string name);
`ifdef FAN_KICKSTART_EN
        for (int i = 0; i < 1024; i++) cyc($sformatf("%s_kick[%0d]", name, i), 1'b0, 1'b0, 1'b1);
        cyc($sformatf("%s_kick_end", name), 1'b0, 1'b0, 1'b0);
`else
        if (name.len() < 0) cyc(name, 1'b0, 1'b0, 1'b0);
`endif
    endtask

    // level = 16'h4000, prescale = 0: carry on every 4th tick.
    task automatic quarter(input string name, input int n);
        for (int i = 0; i < n; i++)
            cyc($sformatf("%s[%0d]", name, i),
                (i % 4 == 3) ? 1'b0 : 1'b1, (i % 4 == 3) ? 1'b1 : 1'b0);
    endtask

    initial begin
        #1 ps_areset = 1'b1;
        @(negedge ps_clk);
        cyc("reset0", 1'b0, 1'b0);
        cyc("reset1", 1'b0, 1'b0);
        ps_areset = 1'b0;
        cyc("idle", 1'b0, 1'b0);

        // Duty 1/4
        level = 16'h4000; prescale = 16'd0; enable = 1'b1;
        kick_wait("q");
        quarter("quarter", 16);
        enable = 1'b0;
        cyc("dis_q", 1'b0, 1'b0);

        // Half duty, prescale 3: first tick on the 4th enabled cycle
        level = 16'h8000; prescale = 16'd3; enable = 1'b1;
        kick_wait("h");
        for (int k = 1; k <= 32; k++) begin
            if (k < 4) cyc($sformatf("half[%0d]", k), 1'b0, 1'b0);
            else if ((((k - 4) / 4) % 2) == 0) cyc($sformatf("half[%0d]", k), 1'b1, 1'b0);
            else cyc($sformatf("half[%0d]", k), 1'b0, 1'b1);
        end
        enable = 1'b0;
        cyc("dis_h", 1'b0, 1'b0);

        // Lowering prescale below the running count ticks at once
        level = 16'h8000; prescale = 16'd9; enable = 1'b1;
        kick_wait("p");
        for (int k = 1; k <= 6; k++) cyc($sformatf("pre9[%0d]", k), 1'b0, 1'b0);
        prescale = 16'd1;
        cyc("pre1[7]", 1'b1, 1'b0);
        cyc("pre1[8]", 1'b1, 1'b0);
        cyc("pre1[9]", 1'b0, 1'b1);
        cyc("pre1[10]", 1'b0, 1'b1);
        cyc("pre1[11]", 1'b1, 1'b0);
        enable = 1'b0;
        cyc("dis_p", 1'b0, 1'b0);

        // level = 0: fan stays off; then disable from fan-off forces it on
        level = 16'h0000; prescale = 16'd0; enable = 1'b1;
        for (int k = 0; k < 16; k++) cyc($sformatf("lvl0[%0d]", k), 1'b1, 1'b0);
        enable = 1'b0;
        cyc("dis_lvl0", 1'b0, 1'b0);

        // level = 16'hFFFF: off for one tick out of every 65536
        level = 16'hFFFF; enable = 1'b1;
        kick_wait("f");
        for (int k = 1; k <= 65540; k++) begin
            if (k == 1 || k == 65537) cyc($sformatf("ffff[%0d]", k), 1'b1, 1'b0);
            else cyc($sformatf("ffff[%0d]", k), 1'b0, 1'b1);
        end
        enable = 1'b0;
        cyc("dis_ffff", 1'b0, 1'b0);

        // Asynchronous reset mid-stream
        level = 16'h4000; prescale = 16'd0; enable = 1'b1;
        kick_wait("a");
        quarter("pre_arst", 6);
        #2 ps_areset = 1'b1;
        #1 check("arst_immediate", {fan_en_b, pdm_bit, kick_active}, 3'b000);
        cyc("arst_held", 1'b0, 1'b0);
        ps_areset = 1'b0;
        kick_wait("ar");
        quarter("post_arst", 12);

        // Soft reset rising together with enable
        enable = 1'b0;
        cyc("dis_s", 1'b0, 1'b0);
        soft_reset = 1'b1; enable = 1'b1; level = 16'h4000;
        cyc("soft_win", 1'b0, 1'b0);
        soft_reset = 1'b0;
        kick_wait("s");
        quarter("post_soft", 8);
        enable = 1'b0;
        cyc("dis_soft", 1'b0, 1'b0);

`ifdef FAN_KICKSTART_EN
        // Kick-start, then no kick with level 0, then an aborted kick
        level = 16'h4000; enable = 1'b1;
        for (int i = 0; i < 1024; i++) cyc($sformatf("kick[%0d]", i), 1'b0, 1'b0, 1'b1);
        cyc("kick_done", 1'b0, 1'b0, 1'b0);
        quarter("post_kick", 8);
        enable = 1'b0;
        cyc("dis_k", 1'b0, 1'b0);
        level = 16'h0000; enable = 1'b1;
        for (int i = 0; i < 4; i++) cyc($sformatf("nokick[%0d]", i), 1'b1, 1'b0, 1'b0);
        enable = 1'b0;
        cyc("dis_nk", 1'b0, 1'b0);
        level = 16'h4000; enable = 1'b1;
        for (int i = 0; i < 10; i++) cyc($sformatf("abort_pre[%0d]", i), 1'b0, 1'b0, 1'b1);
        enable = 1'b0;
        #1 check("abort_immediate", {1'b0, 1'b0, kick_active}, 3'b000);
        cyc("abort_edge", 1'b0, 1'b0, 1'b0);
`endif

        @(negedge ps_clk);
        check("queue_drained", {2'b00, q_exp.size() == 0}, 3'b001);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
